// File: rtl/otp_cipher_engine_pkg.sv
// otp_cipher_pkg: mode encoding, LFSR tap selection and index-width helper
// shared by the otp_cipher_engine files.
package otp_cipher_pkg;

    typedef enum logic {
        MODE_ENC = 1'b0,
        MODE_DEC = 1'b1
    } mode_e;

    // Galois tap mask for a right-shifting LFSR of the given width.
    function automatic logic [31:0] lfsr_taps(input int unsigned width);
        case (width)
            8:       return 32'h0000_00B8;
            16:      return 32'h0000_B400;
            default: return 32'h8020_0003;
        endcase
    endfunction

    // Pad-index width for a store of the given depth.
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/otp_cipher_engine_if.sv
// otp_cipher_engine_if: request/result handshake bundle of the OTP cipher engine.
interface otp_cipher_engine_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IDX_W  = 3
);
    logic              in_valid;
    logic              in_ready;
    logic              mode;
    logic [DATA_W-1:0] in_data;
    logic [IDX_W-1:0]  in_idx;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_err;

    modport master (
        output in_valid, mode, in_data, in_idx, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_err
    );

    modport slave (
        input  in_valid, mode, in_data, in_idx, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_err
    );
endinterface

// File: rtl/otp_cipher_engine_lfsr.sv
// otp_lfsr: free-running right-shift Galois LFSR producing one pad per advance.
// A zero seed is replaced by 1 so the register never locks up.
module otp_lfsr
    import otp_cipher_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter logic [31:0] SEED  = 32'd1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    output logic [WIDTH-1:0] state
);
    localparam logic [WIDTH-1:0] TAPS   = WIDTH'(lfsr_taps(WIDTH));
    localparam logic [WIDTH-1:0] SEED_W = (SEED[WIDTH-1:0] == '0) ? WIDTH'(1) : SEED[WIDTH-1:0];

    logic [WIDTH-1:0] state_q, state_d;

    // Next state: shift right, fold the taps in when a one falls out.
    always_comb begin
        state_d = state_q >> 1;
        if (state_q[0]) begin
            state_d = state_d ^ TAPS;
        end
    end

    // State register, advances only when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED_W;
        end else if (adv) begin
            state_q <= state_d;
        end
    end

    assign state = state_q;
endmodule

// File: rtl/otp_cipher_engine.sv
// otp_cipher_engine: one-time-pad encrypt/decrypt with an indexed pad store,
// valid/ready handshake and a single registered result.
// Optional build macro OTP_BURN_AFTER_READ_EN: each pad decrypts once and
// encrypt refuses to overwrite a still-valid entry.
module otp_cipher_engine
    import otp_cipher_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 8,
    parameter logic [31:0] LFSR_SEED = 32'd1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    otp_cipher_engine_if.slave        bus,
    output logic [idx_width(DEPTH):0] used_count
);
    localparam int unsigned    IDX_W   = idx_width(DEPTH);
    localparam logic [IDX_W:0] DEPTH_C = (IDX_W + 1)'(DEPTH);
    localparam logic [IDX_W:0] CNT_ONE = (IDX_W + 1)'(1);
    localparam logic [IDX_W-1:0] PTR_ONE = IDX_W'(1);

    logic [DATA_W-1:0] pad;
    logic [DATA_W-1:0] store_q [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [IDX_W:0]    used_q, used_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [IDX_W-1:0]  out_idx_q, out_idx_d;
    logic              out_err_q, out_err_d;

    logic              accept;
    logic              wr_en;
    logic              clr_hit;
    logic [DATA_W-1:0] res_data;
    logic [IDX_W-1:0]  res_idx;
    logic              res_err;

    otp_lfsr #(
        .WIDTH (DATA_W),
        .SEED  (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (en),
        .state (pad)
    );

    assign bus.in_ready = en & (~out_valid_q | bus.out_ready);
    assign accept       = bus.in_valid & bus.in_ready;

    // Request decode: result word plus which store update it implies.
    always_comb begin
        res_data = '0;
        res_idx  = wr_ptr_q;
        res_err  = 1'b0;
        wr_en    = 1'b0;
        clr_hit  = 1'b0;
        if (mode_e'(bus.mode) == MODE_ENC) begin
`ifdef OTP_BURN_AFTER_READ_EN
            if (valid_q[wr_ptr_q]) begin
                res_err = 1'b1;
            end else begin
                res_data = bus.in_data ^ pad;
                wr_en    = 1'b1;
            end
`else
            res_data = bus.in_data ^ pad;
            wr_en    = 1'b1;
`endif
        end else begin
            res_idx = bus.in_idx;
            if (valid_q[bus.in_idx]) begin
                res_data = bus.in_data ^ store_q[bus.in_idx];
`ifdef OTP_BURN_AFTER_READ_EN
                clr_hit  = 1'b1;
`endif
            end else begin
                res_err = 1'b1;
            end
        end
    end

    // Next state for valid bits, write pointer, occupancy and result register.
    always_comb begin
        valid_d     = valid_q;
        wr_ptr_d    = wr_ptr_q;
        used_d      = used_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_err_d   = out_err_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = res_data;
            out_idx_d   = res_idx;
            out_err_d   = res_err;
            if (wr_en) begin
                valid_d[wr_ptr_q] = 1'b1;
                wr_ptr_d          = wr_ptr_q + PTR_ONE;
                if (!valid_q[wr_ptr_q] && used_q != DEPTH_C) begin
                    used_d = used_q + CNT_ONE;
                end
            end
            if (clr_hit) begin
                valid_d[bus.in_idx] = 1'b0;
                if (used_q != '0) begin
                    used_d = used_q - CNT_ONE;
                end
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Control and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            wr_ptr_q    <= '0;
            used_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            wr_ptr_q    <= wr_ptr_d;
            used_q      <= used_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_err_q   <= out_err_d;
        end
    end

    // Pad store data; validity lives in valid_q so the array needs no reset.
    always_ff @(posedge clk) begin
        if (accept && wr_en) begin
            store_q[wr_ptr_q] <= pad;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_err   = out_err_q;
    assign used_count    = used_q;
endmodule

// File: tb/tb_otp_cipher_engine.sv
// tb_otp_cipher_engine: scoreboard bench for otp_cipher_engine (DATA_W=8, DEPTH=8).
module tb_otp_cipher_engine;
    import otp_cipher_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned DP = 8;
    localparam int unsigned IW = 3;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [IW-1:0] idx;
        logic          err;
    } res_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [IW:0]   used_count;
    int unsigned   n_checks;
    int unsigned   n_fail;
    res_t          exp_q[$];
    res_t          obs_q[$];

    logic [DW-1:0] m_lfsr;
    logic [DW-1:0] m_store [DP];
    logic [DP-1:0] m_valid;
    logic [IW-1:0] m_wr;
    logic [IW:0]   m_used;
    logic          m_ov;

    always #5 clk = ~clk;

    otp_cipher_engine_if #(.DATA_W(DW), .IDX_W(IW)) bus ();

    otp_cipher_engine #(
        .DATA_W    (DW),
        .DEPTH     (DP),
        .LFSR_SEED (32'd1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .bus        (bus),
        .used_count (used_count)
    );

    function automatic logic [DW-1:0] lfsr_next(input logic [DW-1:0] s);
        return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
    endfunction

    task automatic model_reset();
        m_lfsr  = 8'h01;
        m_valid = '0;
        m_wr    = '0;
        m_used  = '0;
        m_ov    = 1'b0;
        exp_q.delete();
        obs_q.delete();
    endtask

    // Reference behaviour for one accepted request; pushes the expected result.
    task automatic model_accept();
        res_t r;
        r = '0;
        if (bus.mode == MODE_ENC) begin
            r.idx = m_wr;
`ifdef OTP_BURN_AFTER_READ_EN
            if (m_valid[m_wr]) begin
                r.err = 1'b1;
            end else begin
`endif
                r.data = bus.in_data ^ m_lfsr;
                m_store[m_wr] = m_lfsr;
                if (!m_valid[m_wr]) m_used = m_used + 1;
                m_valid[m_wr] = 1'b1;
                m_wr = m_wr + 1;
`ifdef OTP_BURN_AFTER_READ_EN
            end
`endif
        end else begin
            r.idx = bus.in_idx;
            if (m_valid[bus.in_idx]) begin
                r.data = bus.in_data ^ m_store[bus.in_idx];
`ifdef OTP_BURN_AFTER_READ_EN
                m_valid[bus.in_idx] = 1'b0;
                m_used = m_used - 1;
`endif
            end else begin
                r.err = 1'b1;
            end
        end
        exp_q.push_back(r);
    endtask

    // One clock: record a result leaving the DUT, update the model, advance to next negedge.
    task automatic step();
        res_t r;
        #1;
        if (bus.out_valid && bus.out_ready) begin
            r.data = bus.out_data;
            r.idx  = bus.out_idx;
            r.err  = bus.out_err;
            obs_q.push_back(r);
        end
        if (bus.in_valid && en && (!m_ov || bus.out_ready)) begin
            model_accept();
            m_ov = 1'b1;
        end else if (bus.out_ready) begin
            m_ov = 1'b0;
        end
        if (en) m_lfsr = lfsr_next(m_lfsr);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic m, input logic [DW-1:0] d, input logic [IW-1:0] i);
        bus.in_valid = 1'b1;
        bus.mode     = m;
        bus.in_data  = d;
        bus.in_idx   = i;
    endtask

    task automatic reset_dut();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", bus.out_valid); end
        n_checks++;
        if (bus.out_data !== 8'h00 || bus.out_idx !== 3'd0 || bus.out_err !== 1'b0) begin
            n_fail++; $display("FAIL rst_out: got data=%h idx=%0d err=%b expected 00/0/0", bus.out_data, bus.out_idx, bus.out_err);
        end
        n_checks++;
        if (used_count !== 4'd0) begin n_fail++; $display("FAIL rst_used: got %0d expected 0", used_count); end
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 0", bus.in_ready); end
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_round_trip();
        res_t o, e;
        rst_n = 1'b1;
        en    = 1'b1;
        drive(MODE_ENC, 8'h00, 3'd0);
        step();
        n_checks++;
        if (bus.out_data !== 8'h01 || bus.out_idx !== 3'd0 || used_count !== 4'd1) begin
            n_fail++; $display("FAIL first_enc: got data=%h idx=%0d used=%0d expected 01/0/1", bus.out_data, bus.out_idx, used_count);
        end
        drive(MODE_ENC, 8'h5A, 3'd0);
        step();
        n_checks++;
        if (bus.out_data !== 8'hE2 || bus.out_idx !== 3'd1) begin
            n_fail++; $display("FAIL rt_enc: got data=%h idx=%0d expected E2/1", bus.out_data, bus.out_idx);
        end
        drive(MODE_DEC, 8'hE2, 3'd1);
        step();
        n_checks++;
        if (bus.out_data !== 8'h5A || bus.out_err !== 1'b0 || bus.out_idx !== 3'd1) begin
            n_fail++; $display("FAIL rt_dec: got data=%h idx=%0d err=%b expected 5A/1/0", bus.out_data, bus.out_idx, bus.out_err);
        end
        bus.in_valid = 1'b0;
        step();
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rt_count: got %0d results expected %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL rt_sb: got %h/%0d/%b expected %h/%0d/%b", o.data, o.idx, o.err, e.data, e.idx, e.err); end
        end
    endtask

    task automatic test_en_low();
        res_t o, e;
        en = 1'b0;
        drive(MODE_ENC, 8'h11, 3'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL en_low_ready: got %b expected 0", bus.in_ready); end
            step();
        end
        n_checks++;
        if (used_count !== m_used) begin n_fail++; $display("FAIL en_low_used: got %0d expected %0d", used_count, m_used); end
        en = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL en_count: got %0d results expected %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL en_sb: got %h/%0d/%b expected %h/%0d/%b", o.data, o.idx, o.err, e.data, e.idx, e.err); end
        end
    endtask

    task automatic test_backpressure();
        res_t o, e;
        bus.out_ready = 1'b0;
        drive(MODE_ENC, 8'hA5, 3'd0);
        step();
        drive(MODE_ENC, 8'h3C, 3'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
                n_fail++; $display("FAIL bp_hold: got in_ready=%b out_valid=%b expected 0/1", bus.in_ready, bus.out_valid);
            end
            n_checks++;
            if (bus.out_data !== exp_q[exp_q.size()-1].data) begin
                n_fail++; $display("FAIL bp_stable: got %h expected %h", bus.out_data, exp_q[exp_q.size()-1].data);
            end
            step();
        end
        bus.out_ready = 1'b1;
        step();
        drive(MODE_ENC, 8'hC3, 3'd0);
        step();
        bus.in_valid = 1'b0;
        step();
        n_checks++;
        if (obs_q.size() !== 3 || exp_q.size() !== 3) begin
            n_fail++; $display("FAIL bp_count: got %0d results for %0d requests expected 3", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL bp_sb: got %h/%0d/%b expected %h/%0d/%b", o.data, o.idx, o.err, e.data, e.idx, e.err); end
        end
    endtask

    task automatic test_invalid_index();
        res_t o, e;
        bus.out_ready = 1'b0;
        drive(MODE_ENC, 8'h77, 3'd0);
        step();
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || used_count !== 4'd0) begin
            n_fail++; $display("FAIL async_rst: got valid=%b data=%h used=%0d expected 0/00/0", bus.out_valid, bus.out_data, used_count);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        drive(MODE_DEC, 8'h33, 3'd5);
        step();
        n_checks++;
        if (bus.out_err !== 1'b1 || bus.out_data !== 8'h00 || bus.out_idx !== 3'd5) begin
            n_fail++; $display("FAIL inv_idx: got err=%b data=%h idx=%0d expected 1/00/5", bus.out_err, bus.out_data, bus.out_idx);
        end
        bus.in_valid = 1'b0;
        step();
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL inv_count: got %0d results expected %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL inv_sb: got %h/%0d/%b expected %h/%0d/%b", o.data, o.idx, o.err, e.data, e.idx, e.err); end
        end
    endtask

`ifdef OTP_BURN_AFTER_READ_EN
    task automatic test_burn();
        res_t o, e;
        reset_dut();
        drive(MODE_ENC, 8'h10, 3'd0);
        step();
        drive(MODE_DEC, 8'h11, 3'd0);
        step();
        n_checks++;
        if (bus.out_data !== 8'h10 || bus.out_err !== 1'b0 || used_count !== 4'd0) begin
            n_fail++; $display("FAIL burn_first: got data=%h err=%b used=%0d expected 10/0/0", bus.out_data, bus.out_err, used_count);
        end
        step();
        n_checks++;
        if (bus.out_err !== 1'b1 || bus.out_data !== 8'h00) begin
            n_fail++; $display("FAIL burn_second: got err=%b data=%h expected 1/00", bus.out_err, bus.out_data);
        end
        bus.in_valid = 1'b0;
        step();
        reset_dut();
        for (int i = 0; i < 9; i++) begin
            drive(MODE_ENC, 8'(i * 13 + 1), 3'd0);
            step();
        end
        n_checks++;
        if (bus.out_err !== 1'b1 || bus.out_idx !== 3'd0 || bus.out_data !== 8'h00 || used_count !== 4'd8) begin
            n_fail++; $display("FAIL burn_full: got err=%b idx=%0d data=%h used=%0d expected 1/0/00/8", bus.out_err, bus.out_idx, bus.out_data, used_count);
        end
        bus.in_valid = 1'b0;
        step();
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL burn_count: got %0d results expected %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL burn_sb: got %h/%0d/%b expected %h/%0d/%b", o.data, o.idx, o.err, e.data, e.idx, e.err); end
        end
    endtask
`else
    task automatic test_wrap();
        res_t o, e;
        logic [DW-1:0] c9;
        reset_dut();
        for (int i = 0; i < 9; i++) begin
            drive(MODE_ENC, 8'(i * 17 + 3), 3'd0);
            step();
        end
        #1;
        n_checks++;
        if (bus.out_idx !== 3'd0 || used_count !== 4'd8 || bus.out_err !== 1'b0) begin
            n_fail++; $display("FAIL wrap_ninth: got idx=%0d used=%0d err=%b expected 0/8/0", bus.out_idx, used_count, bus.out_err);
        end
        c9 = exp_q[exp_q.size()-1].data;
        drive(MODE_DEC, c9, 3'd0);
        step();
        n_checks++;
        if (bus.out_data !== 8'h8B || bus.out_err !== 1'b0) begin
            n_fail++; $display("FAIL wrap_dec: got data=%h err=%b expected 8B/0", bus.out_data, bus.out_err);
        end
        bus.in_valid = 1'b0;
        step();
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL wrap_count: got %0d results expected %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL wrap_sb: got %h/%0d/%b expected %h/%0d/%b", o.data, o.idx, o.err, e.data, e.idx, e.err); end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        en            = 1'b0;
        bus.in_valid  = 1'b0;
        bus.mode      = 1'b0;
        bus.in_data   = '0;
        bus.in_idx    = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_round_trip();
        test_en_low();
        test_backpressure();
        test_invalid_index();
`ifdef OTP_BURN_AFTER_READ_EN
        test_burn();
`else
        test_wrap();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/otp_cipher_engine.md
# otp_cipher_engine

Parametrised one-time-pad cipher engine: a free-running Galois LFSR generates pads, an indexed pad store of DEPTH words keeps each pad for later decryption, and a single output register with a valid/ready handshake returns the ciphertext or plaintext with its pad index. It is the generalised successor of the 8-bit, 8-entry OTP encryptor. It adds configurable word width and store depth, backpressure, occupancy tracking, error reporting and an optional strict burn-after-read mode.

## Interface
Parameters:
- DATA_W, default 8: word and pad width; legal values 8, 16, 32.
- DEPTH, default 8: number of pad-store entries; power of two, 2..64.
- LFSR_SEED, default 1: LFSR reset value; 0 is replaced by 1.

Ports (IDX_W = log2(DEPTH)):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- en  in  1  engine enable; when low, all state holds.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted this cycle if in_valid is also high.
- mode  in  1  0 = encrypt, 1 = decrypt.
- in_data  in  DATA_W  plaintext (encrypt) or ciphertext (decrypt).
- in_idx  in  IDX_W  pad index for decrypt; ignored for encrypt.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  DATA_W  result word.
- out_idx  out  IDX_W  pad index used.
- out_err  out  1  request failed; out_data is forced to 0.
- used_count  out  IDX_W+1  number of valid store entries.

## Operation
- **Accept rule:** `in_ready = en & (~out_valid | out_ready)`. A request is accepted on a rising edge where `in_valid & in_ready`.
- **LFSR:** right-shift Galois LFSR.
  - Advances on every clk edge where en=1, whether or not a request is accepted.
  - The pad is the LFSR state during the accept cycle.
  - Taps: 0xB8 (8-bit), 0xB400 (16-bit), 0x80200003 (32-bit).
- **Encrypt:**
  - Entry wr_ptr is written with the pad, and its valid bit is set.
  - out_data = in_data ^ pad; out_idx = wr_ptr; out_err = 0.
  - wr_ptr increments and wraps from DEPTH-1 to 0.
- **Decrypt:**
  - If entry in_idx is valid: out_data = in_data ^ store[in_idx]; out_idx = in_idx; out_err = 0.
  - If entry in_idx is invalid: out_err = 1, out_data = 0, out_idx = in_idx.
- **Occupancy:** used_count tracks set valid bits; it saturates at DEPTH and never underflows.
- **en low:**
  - in_ready = 0; LFSR, pointers and store hold.
  - A pending out_valid is still held until out_ready.
- **Reset (asynchronous, also mid-transfer):**
  - out_valid = 0, out_data = 0, out_idx = 0, out_err = 0.
  - wr_ptr = 0, all valid bits = 0, used_count = 0, LFSR = seed.
  - Store data need not be cleared.

## Timing
- Latency is 1 cycle: a request accepted at edge N gives out_valid=1 after edge N.
- Throughput is 1 request per cycle while out_ready=1.
- out_valid holds, with out_data, out_idx and out_err stable, until the edge where out_ready=1.
- If a new request is accepted on that same edge, out_valid stays 1 with the new result.
- A decrypt of an entry written by an encrypt accepted on the previous edge sees the new pad (write-before-read across cycles).

## Configuration
Macro: OTP_BURN_AFTER_READ_EN.
- **Defined:**
  - A successful decrypt clears the entry's valid bit and decrements used_count, so each pad decrypts exactly once.
  - Encrypt when entry wr_ptr is still valid: out_err = 1, out_data = 0, out_idx = wr_ptr; wr_ptr does not advance and the store is unchanged.
- **Undefined:**
  - Decrypt never clears valid bits.
  - Encrypt always overwrites entry wr_ptr and never errors.
  - used_count saturates at DEPTH.

## Structure
- **Package otp_cipher_pkg:**
  - mode encoding constants MODE_ENC and MODE_DEC.
  - function lfsr_taps(width) returning the tap mask.
  - function clog2-based IDX_W helper.
- **Sub-module otp_lfsr (parameters WIDTH, SEED):**
  - ports clk, rst_n, adv, state.
  - Instantiated once.
- The pad store is a flop array with a separate valid-bit vector in the top level.

## Test plan
- **Reset and first encrypt:** DATA_W=8, seed 1. Release reset, en=1, encrypt 0x00 on the first cycle -> out_data=0x01, out_idx=0, used_count=1. The LFSR then reads 0xB8.
- **Round trip:** encrypt 0x5A with pad 0xB8 -> out_data=0xE2, idx=1. Decrypt 0xE2 at idx 1 -> out_data=0x5A, out_err=0.
- **Invalid index:** after reset, decrypt 0x33 at idx 5 -> out_err=1, out_data=0x00.
- **Backpressure:** hold out_ready=0 for 3 cycles -> in_ready=0 and out_data stable throughout. Raising out_ready together with a new request -> back-to-back results, none lost.
- **Burn after read (macro defined):** decrypt the same idx twice -> the second decrypt gives out_err=1 and used_count drops by 1. Fill all 8 entries, then a 9th encrypt -> out_err=1 and wr_ptr stays 0.
- **Wrap without macro:** perform 9 encrypts -> the 9th gives out_idx=0 and used_count=8. Decrypting idx 0 uses the 9th pad.
